// File: rtl/audio_pkg.sv
// Purpose: shared types and constants for the audio sample FIFO block.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package audio_pkg;

    // Playback state: PRIME fills the buffer, PLAY drains one byte per request.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_PLAY  = 1'b1
    } state_t;

    // Unsigned 8-bit midscale, i.e. silence for the driver.
    localparam logic [7:0] AUDIO_IDLE_VALUE = 8'h80;

    // Width of the underrun/overrun event counters.
    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_fifo_ram.sv
// Purpose: DEPTH x DW simple dual-port storage for the audio sample FIFO.
// Latency: write lands on the clk edge; read is combinational from rd_addr.
// Backpressure: none; the caller guarantees it never writes a full FIFO.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module sample_fifo_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // No reset on the array: emptiness is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read keeps pop latency at one cycle with rd_ptr as address.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Purpose: elastic byte buffer from UART RX to the I2S driver with priming, underrun fill and RTS throttling.
// Latency: byte poppable the cycle after push; mono_sample updates 4 clk after a sample_tick rise.
// Backpressure: rts_n hysteresis on level (HI_WM/LO_WM); bytes arriving while full are dropped and counted.
// Ports: clk/rst_n; rx_data/rx_valid push side; sample_tick request in; mono_sample out;
//        rts_n host flow control; playing, level, underrun_cnt, overrun_cnt status.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int         DEPTH       = 256,
    parameter int         AW          = 8,
    parameter int         PRIME_LEVEL = 128,
    parameter int         HI_WM       = 192,
    parameter int         LO_WM       = 64,
    parameter logic [7:0] IDLE_VALUE  = AUDIO_IDLE_VALUE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             sample_tick,
    output logic [7:0]       mono_sample,
    output logic             rts_n,
    output logic             playing,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    if (!(LO_WM < HI_WM && HI_WM <= DEPTH && PRIME_LEVEL <= DEPTH && DEPTH == (1 << AW)))
    begin : g_bad_params
        $error("audio_sample_fifo: illegal DEPTH/AW/PRIME_LEVEL/HI_WM/LO_WM combination");
    end

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LEVEL);
    localparam logic [AW:0] HI_L    = (AW+1)'(HI_WM);
    localparam logic [AW:0] LO_L    = (AW+1)'(LO_WM);

    // ------------------------------------------------------------------
    // sample_tick synchroniser and rising-edge detector. req is registered,
    // so it rises on the third clk edge after the tick is first sampled.
    // ------------------------------------------------------------------
    logic tick_s1, tick_s2, tick_s2_d, req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_s2_d <= 1'b0;
            req       <= 1'b0;
        end else begin
            tick_s1   <= sample_tick;
            tick_s2   <= tick_s1;
            tick_s2_d <= tick_s2;
            req       <= tick_s2 & ~tick_s2_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    state_t        state;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    head;
    logic          full, empty, push, pop, underrun;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // A full FIFO drops the byte even if a pop frees a slot this same cycle.
    assign push     = rx_valid && !full;
    // No write-through: a byte pushed into an empty FIFO is not poppable yet.
    assign pop      = (state == ST_PLAY) && req && !empty;
    assign underrun = (state == ST_PLAY) && req && empty;

    sample_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Level is its own counter so full (DEPTH) and empty (0) are distinct
    // without an extra pointer wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Playback state machine, output sample and underrun accounting.
    // The PRIME->PLAY decision uses the registered level, so a req in the
    // cycle level first reaches PRIME_LEVEL is still ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_PRIME;
            mono_sample  <= IDLE_VALUE;
            underrun_cnt <= '0;
        end else begin
            case (state)
                ST_PRIME: begin
                    mono_sample <= IDLE_VALUE;
                    if (level >= PRIME_L) begin
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pop) begin
                        mono_sample <= head;
                    end else if (underrun) begin
                        mono_sample  <= IDLE_VALUE;
                        underrun_cnt <= sat_inc(underrun_cnt);
                        state        <= ST_PRIME;
                    end
                end
                default: begin
                    state       <= ST_PRIME;
                    mono_sample <= IDLE_VALUE;
                end
            endcase
        end
    end

    assign playing = (state == ST_PLAY);

    // ------------------------------------------------------------------
    // Overrun accounting and RTS hysteresis on the registered level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
            rts_n       <= 1'b0;
        end else begin
            if (rx_valid && full) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
            if (!rts_n && level >= HI_L) begin
                rts_n <= 1'b1;
            end else if (rts_n && level <= LO_L) begin
                rts_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Purpose: directed, table-driven bench for audio_sample_fifo.
// Latency: n/a.
// Backpressure: the RTS scenario models a host that only sends while rts_n is low.
module tb_audio_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sample_tick;
    logic [7:0]  mono_sample;
    logic        rts_n;
    logic        playing;
    logic [8:0]  level;
    logic [15:0] underrun_cnt;
    logic [15:0] overrun_cnt;

    audio_sample_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sample_tick  (sample_tick),
        .mono_sample  (mono_sample),
        .rts_n        (rts_n),
        .playing      (playing),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int next_byte;

    typedef enum int {OP_PUSH, OP_TICK, OP_IDLE} op_t;

    typedef struct {
        string name;
        op_t   op;
        int    arg;
        int    mono;
        int    play;
        int    lvl;
        int    rts;
        int    und;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp_v, exp_v, $time);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        next_byte = 1;
        @(negedge clk);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(next_byte);
            next_byte++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    // One request; mono_sample has settled by the time this returns.
    task automatic tick();
        sample_tick = 1'b1;
        repeat (3) @(negedge clk);
        sample_tick = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Request with a byte pushed on exactly the edge where the pop happens
    // (tick sampled at edge 0, req high after edge 2, pop on edge 3).
    task automatic tick_with_push();
        sample_tick = 1'b1;
        repeat (3) @(negedge clk);
        sample_tick = 1'b0;
        rx_valid    = 1'b1;
        rx_data     = 8'(next_byte);
        next_byte++;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_rts, rts_prev, rise_seen, fall_seen;
        int lvl_prev;

        //          name            op       arg  mono  play lvl  rts und
        vecs[0] = '{"prime_127",    OP_PUSH, 127, 8'h80, 0, 127, 0, 0};
        vecs[1] = '{"tick_priming", OP_TICK, 1,   8'h80, 0, 127, 0, 0};
        vecs[2] = '{"push_128th",   OP_PUSH, 1,   8'h80, 0, 128, 0, 0};
        vecs[3] = '{"play_next",    OP_IDLE, 1,   8'h80, 1, 128, 0, 0};
        vecs[4] = '{"first_pop",    OP_TICK, 1,   8'h01, 1, 127, 0, 0};
        vecs[5] = '{"second_pop",   OP_TICK, 1,   8'h02, 1, 126, 0, 0};

        // ---------------- reset state ----------------
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sample_tick = 1'b0;
        #12;
        check("rst_mono", mono_sample, 8'h80);
        check("rst_rts", rts_n, 0);
        check("rst_playing", playing, 0);
        check("rst_level", level, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_overrun", overrun_cnt, 0);

        // ---------------- priming and first samples (table) ----------------
        do_reset();
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PUSH: push_n(vecs[i].arg);
                OP_TICK: repeat (vecs[i].arg) tick();
                default: repeat (vecs[i].arg) @(negedge clk);
            endcase
            check({vecs[i].name, "_mono"}, mono_sample, vecs[i].mono);
            check({vecs[i].name, "_playing"}, playing, vecs[i].play);
            check({vecs[i].name, "_level"}, level, vecs[i].lvl);
            check({vecs[i].name, "_rts"}, rts_n, vecs[i].rts);
            check({vecs[i].name, "_underrun"}, underrun_cnt, vecs[i].und);
        end

        // Drain the rest in order (0x03..0x80), then underrun on empty.
        for (int k = 3; k <= 128; k++) begin
            tick();
            check("drain_order", mono_sample, k);
        end
        check("drain_level", level, 0);
        check("drain_playing", playing, 1);
        tick();
        check("underrun_mono", mono_sample, 8'h80);
        check("underrun_cnt", underrun_cnt, 1);
        check("underrun_playing", playing, 0);

        // ---------------- RTS hysteresis ----------------
        do_reset();
        exp_rts = 1'b0; rts_prev = 1'b0; rise_seen = 1'b0; fall_seen = 1'b0; lvl_prev = 0;
        for (int c = 0; c < 14000 && !fall_seen; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (!exp_rts && lvl_prev >= 192)
                    exp_rts = 1'b1;
                else if (exp_rts && lvl_prev <= 64)
                    exp_rts = 1'b0;
                check("rts_hysteresis", rts_n, exp_rts);
            end
            if (rts_n && !rts_prev) rise_seen = 1'b1;
            if (!rts_n && rts_prev && rise_seen) fall_seen = 1'b1;
            rts_prev = rts_n;
            lvl_prev = level;
            rx_valid = (c % 20 == 0) && !rts_n;
            if (rx_valid) begin
                rx_data = 8'(next_byte);
                next_byte++;
            end
            sample_tick = (c % 32) < 8;
        end
        rx_valid = 1'b0; sample_tick = 1'b0;
        check("rts_rise_seen", rise_seen, 1);
        check("rts_fall_seen", fall_seen, 1);
        check("rts_no_underrun", underrun_cnt, 0);

        // ---------------- overrun while full ----------------
        do_reset();
        push_n(256);
        check("full_level", level, 256);
        check("full_rts", rts_n, 1);
        push_n(2);
        check("overrun_2", overrun_cnt, 2);
        tick_with_push();
        check("overrun_3", overrun_cnt, 3);
        check("overrun_level", level, 255);
        check("overrun_first_out", mono_sample, 8'h01);
        for (int k = 2; k <= 256; k++) begin
            tick();
            check("overrun_order", mono_sample, k % 256);
        end
        check("overrun_drained", level, 0);
        check("overrun_no_underrun", underrun_cnt, 0);

        // ---------------- push and pop together at level 100 ----------------
        do_reset();
        push_n(128);
        @(negedge clk);
        repeat (28) tick();
        check("pp_level_before", level, 100);
        tick_with_push();
        check("pp_level_after", level, 100);
        check("pp_mono", mono_sample, 29);

        // ---------------- asynchronous reset mid-stream ----------------
        push_n(100);
        repeat (2) @(negedge clk);
        check("pre_arst_rts", rts_n, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mono", mono_sample, 8'h80);
        check("arst_level", level, 0);
        check("arst_rts", rts_n, 0);
        check("arst_playing", playing, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
